chacha_keystream_ctrl: RTL

- Sequences the one-round-per-cycle ChaCha20 core (20 rounds, start/done pulse handshake) to produce a continuous keystream.
- Assembles the 512-bit input state from a configured key, nonce and block counter, then pulses the core start.
- Captures each feed-forwarded output block and serializes it onto a valid/ready stream of OUT_W-bit beats.
- Launches the next block while the current one drains, so the core stays busy under backpressure.

---
 rtl/chacha_pkg.sv | 46 ++++
 rtl/chacha_ks_serializer.sv | 90 +++++++++
 rtl/chacha_keystream_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared ChaCha20 definitions: word/state widths, sigma constants, launch FSM
// encoding and the 512-bit input-state layout with its assembly helper.
package chacha_pkg;

  localparam int unsigned STATE_W = 512;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned KEY_W   = 256;
  localparam int unsigned NONCE_W = 96;

  // "expand 32-byte k"
  localparam logic [WORD_W-1:0] SIGMA0 = 32'h61707865;
  localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320646e;
  localparam logic [WORD_W-1:0] SIGMA2 = 32'h79622d32;
  localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b206574;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } launch_state_e;

  // Word 0 sits in the most-significant position.
  typedef struct packed {
    logic [WORD_W-1:0]  sigma0;
    logic [WORD_W-1:0]  sigma1;
    logic [WORD_W-1:0]  sigma2;
    logic [WORD_W-1:0]  sigma3;
    logic [KEY_W-1:0]   key;
    logic [WORD_W-1:0]  ctr;
    logic [NONCE_W-1:0] nonce;
  } chacha_state_t;

  function automatic chacha_state_t assemble_state(input logic [KEY_W-1:0]   key,
                                                   input logic [NONCE_W-1:0] nonce,
                                                   input logic [WORD_W-1:0]  ctr);
    chacha_state_t s;
    s.sigma0 = SIGMA0;
    s.sigma1 = SIGMA1;
    s.sigma2 = SIGMA2;
    s.sigma3 = SIGMA3;
    s.key    = key;
    s.ctr    = ctr;
    s.nonce  = nonce;
    return s;
  endfunction

endpackage

// File: rtl/chacha_ks_serializer.sv
// Block buffer + beat serializer for the keystream. Holds one 512-bit block,
// presents it MS-beat first on a valid/ready stream, and remembers that one
// more finished block is waiting in the core (pending) so it can be swapped in
// on the last-beat accept without a bubble.
//   blk_valid/blk_data : finished core block (blk_data also used for pending reload)
//   ks_*               : keystream stream
//   pending            : a finished block is parked in the core
//   can_take_c         : a block arriving this cycle would go straight into the buffer
//   occupied_next_c    : buffer or pending will be occupied after this edge
module chacha_ks_serializer
  import chacha_pkg::*;
#(
  parameter int unsigned OUT_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_valid,
  input  logic [STATE_W-1:0] blk_data,
  input  logic               ks_ready,
  output logic               ks_valid,
  output logic [OUT_W-1:0]   ks_data,
  output logic               ks_last,
  output logic               pending,
  output logic               can_take_c,
  output logic               occupied_next_c
);

  localparam int unsigned BEATS  = STATE_W / OUT_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [STATE_W-1:0] blk_q, blk_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               full_d, pend_d, last_d;
  logic               accept, last_acc;

  // Buffer shifts left on each accept so the current beat is always the top slice.
  assign ks_data = blk_q[STATE_W-1 -: OUT_W];

  // Next-state for buffer, beat index, occupancy and pending flag.
  always_comb begin
    blk_d    = blk_q;
    beat_d   = beat_q;
    full_d   = ks_valid;
    pend_d   = pending;
    accept   = ks_valid && ks_ready;
    last_acc = accept && ks_last;
    can_take_c = !ks_valid || last_acc;

    if (blk_valid && can_take_c) begin
      blk_d  = blk_data;
      beat_d = '0;
      full_d = 1'b1;
    end else if (blk_valid) begin
      pend_d = 1'b1;
    end else if (last_acc) begin
      if (pending) begin
        // Core output is still held stable, reload straight from it.
        blk_d  = blk_data;
        beat_d = '0;
        pend_d = 1'b0;
      end else begin
        full_d = 1'b0;
      end
    end else if (accept) begin
      blk_d  = blk_q << OUT_W;
      beat_d = beat_q + BEAT_W'(1);
    end

    last_d          = full_d && (beat_d == BEAT_W'(BEATS - 1));
    occupied_next_c = full_d || pend_d;
  end

  // Serializer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q    <= '0;
      beat_q   <= '0;
      ks_valid <= 1'b0;
      ks_last  <= 1'b0;
      pending  <= 1'b0;
    end else begin
      blk_q    <= blk_d;
      beat_q   <= beat_d;
      ks_valid <= full_d;
      ks_last  <= last_d;
      pending  <= pend_d;
    end
  end

endmodule

// File: rtl/chacha_keystream_ctrl.sv
// ChaCha20 keystream controller: holds key/nonce/counter, launches the
// one-round-per-cycle core and streams each result as OUT_W-bit beats.
//   cfg_*          : configuration, accepted only while idle (busy=0)
//   enable         : permit new core starts
//   ks_*           : keystream valid/ready stream, ks_last on final beat of a block
//   ctr_wrap       : sticky, block with counter 0xFFFFFFFF has been issued
//   busy           : core in flight, result pending or buffer non-empty
//   core_*         : start/done handshake and state to/from the core
module chacha_keystream_ctrl
  import chacha_pkg::*;
#(
  parameter int unsigned OUT_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [KEY_W-1:0]   cfg_key,
  input  logic [NONCE_W-1:0] cfg_nonce,
  input  logic [WORD_W-1:0]  cfg_ctr,
  input  logic               enable,
  output logic               ks_valid,
  input  logic               ks_ready,
  output logic [OUT_W-1:0]   ks_data,
  output logic               ks_last,
  output logic               ctr_wrap,
  output logic               busy,
  output logic               core_start,
  output logic [STATE_W-1:0] core_state_in,
  input  logic [STATE_W-1:0] core_state_out,
  input  logic               core_done
);

  launch_state_e      state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_eff;
  logic [NONCE_W-1:0] nonce_q, nonce_eff;
  logic [WORD_W-1:0]  ctr_q, ctr_eff, ctr_d;
  logic               wrap_eff, wrap_d, start_d, busy_d;
  logic [STATE_W-1:0] state_in_d;
  logic               cfg_take, blk_done, launch;
  logic               ser_pending, ser_take_c, ser_occ_next_c;

  chacha_ks_serializer #(.OUT_W(OUT_W)) u_ser (
    .clk             (clk),
    .rst_n           (rst_n),
    .blk_valid       (blk_done),
    .blk_data        (core_state_out),
    .ks_ready        (ks_ready),
    .ks_valid        (ks_valid),
    .ks_data         (ks_data),
    .ks_last         (ks_last),
    .pending         (ser_pending),
    .can_take_c      (ser_take_c),
    .occupied_next_c (ser_occ_next_c)
  );

  // Launch FSM, config capture and state assembly. A cfg_load accepted this
  // cycle is bypassed into the launch so the first start uses the new config.
  always_comb begin
    cfg_take  = cfg_load && !busy;
    key_eff   = cfg_take ? cfg_key   : key_q;
    nonce_eff = cfg_take ? cfg_nonce : nonce_q;
    ctr_eff   = cfg_take ? cfg_ctr   : ctr_q;
    wrap_eff  = cfg_take ? 1'b0      : ctr_wrap;
    blk_done  = (state_q == WAIT) && core_done;

    state_d    = state_q;
    launch     = 1'b0;
    start_d    = 1'b0;
    state_in_d = core_state_in;
    ctr_d      = ctr_eff;
    wrap_d     = wrap_eff;

    case (state_q)
      IDLE: begin
        if (enable && !wrap_eff && !ser_pending) launch = 1'b1;
      end
      WAIT: begin
        // Relaunch on the done cycle when the result will not need parking.
        if (core_done) begin
          if (enable && !wrap_eff && ser_take_c) launch = 1'b1;
          else                                   state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      start_d    = 1'b1;
      state_in_d = assemble_state(key_eff, nonce_eff, ctr_eff);
      ctr_d      = ctr_eff + WORD_W'(1);
      if (ctr_eff == '1) wrap_d = 1'b1;
      state_d    = WAIT;
    end

    busy_d = (state_d == WAIT) || ser_occ_next_c;
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      key_q         <= '0;
      nonce_q       <= '0;
      ctr_q         <= '0;
      ctr_wrap      <= 1'b0;
      core_start    <= 1'b0;
      core_state_in <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_eff;
      nonce_q       <= nonce_eff;
      ctr_q         <= ctr_d;
      ctr_wrap      <= wrap_d;
      core_start    <= start_d;
      core_state_in <= state_in_d;
      busy          <= busy_d;
    end
  end

endmodule
